// File: rtl/fft_pkg.sv
// Shared FFT types and helpers: sample types used by every pipeline stage,
// the FSM state enums of the reorder stage, and the bit-reversal helper.
package fft_pkg;

  localparam int FPT_W = 32;
  localparam int MAX_N = 16;

  typedef logic signed [FPT_W-1:0] fpt;
  typedef fpt [1:0] cpx;

  typedef enum logic {WR_IDLE, WR_FILL} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DRAIN} rd_state_t;

  // Reverses the low n bits of k; bits at and above n come back as zero.
  function automatic logic [MAX_N-1:0] bitrev(input logic [MAX_N-1:0] k, input int n);
    logic [MAX_N-1:0] r;
    logic [MAX_N-1:0] kk;
    r  = '0;
    kk = k;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        r  = (r << 1) | {{(MAX_N-1){1'b0}}, kk[0]};
        kk = kk >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank frame buffer for the bit-reversal stage: one write port and one
// registered read port, each selecting its own bank.
module fft_pingpong_ram #(
  parameter int N = 3,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           we,
  input  logic           wr_bank,
  input  logic [N-1:0]   wr_addr,
  input  logic [2*W-1:0] wr_data,
  input  logic           rd_en,
  input  logic           rd_bank,
  input  logic [N-1:0]   rd_addr,
  output logic [2*W-1:0] rd_data
);

  localparam int M = 1 << N;

  logic [2*W-1:0] mem [0:2*M-1];

  always_ff @(posedge clk) begin
    if (we) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  // The read register is the stage output, so it clears on reset and holds when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_data <= '0;
    else if (rd_en) rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Final R2SDF stage: buffers each bit-reversed frame in one bank while the
// previous frame is read out of the other bank in natural order.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N = 3,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [2*W-1:0] ip,
  input  logic           start_ip,
  output logic [2*W-1:0] op,
  output logic           op_valid,
  output logic           start_op,
  output logic [N-1:0]   op_idx,
  output logic           frame_err
);

  localparam logic [N-1:0] LAST = '1;

  wr_state_t    wr_state;
  logic [N-1:0] wr_cnt;
  logic         wr_bank;
  logic         wr_last;
  logic         rd_go;
  logic         rd_go_bank;

  rd_state_t    rd_state;
  logic [N-1:0] rd_cnt;
  logic         rd_bank;
  logic         rd_issue;

  logic         ram_we;
  logic         ram_wr_bank;
  logic [N-1:0] ram_wr_addr;
  logic         ram_rd_bank;
  logic [N-1:0] ram_rd_addr;

  assign wr_last = (wr_state == WR_FILL) && (wr_cnt == LAST);

  // A start pulse always lands at address 0; on the last write it opens the next bank.
  always_comb begin
    ram_we      = (wr_state == WR_FILL) || start_ip;
    ram_wr_bank = (wr_last && start_ip) ? ~wr_bank : wr_bank;
    ram_wr_addr = start_ip ? '0 : N'(bitrev(MAX_N'(wr_cnt), N));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state   <= WR_IDLE;
      wr_cnt     <= '0;
      wr_bank    <= 1'b0;
      rd_go      <= 1'b0;
      rd_go_bank <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rd_go     <= 1'b0;
      frame_err <= 1'b0;
      case (wr_state)
        WR_IDLE: begin
          if (start_ip) begin
            wr_cnt   <= N'(1);
            wr_state <= WR_FILL;
          end
        end
        WR_FILL: begin
          if (wr_cnt == LAST) begin
            wr_bank    <= ~wr_bank;
            rd_go      <= 1'b1;
            rd_go_bank <= wr_bank;
            if (start_ip) begin
              wr_cnt <= N'(1);
            end else begin
              wr_cnt   <= '0;
              wr_state <= WR_IDLE;
            end
          end else if (start_ip) begin
            frame_err <= 1'b1;
            wr_cnt    <= N'(1);
          end else begin
            wr_cnt <= wr_cnt + N'(1);
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Sample 0 is read on the same clock rd_go arrives, which saves a cycle of latency.
  always_comb begin
    rd_issue    = (rd_state == RD_DRAIN) || rd_go;
    ram_rd_bank = (rd_state == RD_DRAIN) ? rd_bank : rd_go_bank;
    ram_rd_addr = (rd_state == RD_DRAIN) ? rd_cnt : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state <= RD_IDLE;
      rd_cnt   <= '0;
      rd_bank  <= 1'b0;
      op_valid <= 1'b0;
      start_op <= 1'b0;
      op_idx   <= '0;
    end else begin
      op_valid <= rd_issue;
      start_op <= rd_issue && (ram_rd_addr == '0);
      if (rd_issue) op_idx <= ram_rd_addr;
      case (rd_state)
        RD_IDLE: begin
          if (rd_go) begin
            rd_bank  <= rd_go_bank;
            rd_cnt   <= N'(1);
            rd_state <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (rd_cnt == LAST) begin
            rd_cnt <= '0;
            if (rd_go) rd_bank  <= rd_go_bank;
            else       rd_state <= RD_IDLE;
          end else begin
            rd_cnt <= rd_cnt + N'(1);
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  fft_pingpong_ram #(.N(N), .W(W)) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (ram_we),
    .wr_bank (ram_wr_bank),
    .wr_addr (ram_wr_addr),
    .wr_data (ip),
    .rd_en   (rd_issue),
    .rd_bank (ram_rd_bank),
    .rd_addr (ram_rd_addr),
    .rd_data (op)
  );

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: directed tables and sequences plus random
// frames scored against a frame-level reference model.
module tb_fft_bitrev_reorder;

  localparam int N  = 3;
  localparam int M  = 8;
  localparam int W  = 32;
  localparam int SL = 1024;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [63:0]   ip;
  logic          start_ip;
  logic [63:0]   op;
  logic          op_valid;
  logic          start_op;
  logic [2:0]    op_idx;
  logic          frame_err;

  logic [63:0]   ip1;
  logic          start_ip1;
  logic [63:0]   op1;
  logic          op_valid1;
  logic          start_op1;
  logic [0:0]    op_idx1;
  logic          frame_err1;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt_valid, cnt_start, cnt_err;

  logic        sched_sip [0:SL-1];
  logic [63:0] sched_dat [0:SL-1];
  logic        ex_valid  [0:SL-1];
  logic        ex_start  [0:SL-1];
  logic        ex_err    [0:SL-1];
  logic [63:0] ex_op     [0:SL-1];
  logic [2:0]  ex_idx    [0:SL-1];

  typedef struct {
    logic [31:0] in_re;
    logic [31:0] in_im;
    logic [31:0] exp_re;
    logic [31:0] exp_im;
    logic [2:0]  exp_idx;
  } vec_t;

  vec_t vecs [8];

  fft_bitrev_reorder #(.N(N), .W(W)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ip        (ip),
    .start_ip  (start_ip),
    .op        (op),
    .op_valid  (op_valid),
    .start_op  (start_op),
    .op_idx    (op_idx),
    .frame_err (frame_err)
  );

  fft_bitrev_reorder #(.N(1), .W(W)) u_dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .ip        (ip1),
    .start_ip  (start_ip1),
    .op        (op1),
    .op_valid  (op_valid1),
    .start_op  (start_op1),
    .op_idx    (op_idx1),
    .frame_err (frame_err1)
  );

  always #5 clk = ~clk;

  function automatic int tb_bitrev(int k, int n);
    int r = 0;
    for (int i = 0; i < n; i++) begin
      r = r * 2 + (k % 2);
      k = k / 2;
    end
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    start_ip  = 1'b0;
    start_ip1 = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic clear_schedule();
    for (int i = 0; i < SL; i++) begin
      sched_sip[i] = 1'b0;
      sched_dat[i] = '0;
      ex_valid[i]  = 1'b0;
      ex_start[i]  = 1'b0;
      ex_err[i]    = 1'b0;
      ex_op[i]     = '0;
      ex_idx[i]    = '0;
    end
  endtask

  // Frame-level model: M uninterrupted samples after a start form one frame that
  // appears in natural order starting the clock after its last sample; a new
  // start 1..M-2 samples into a frame discards it and flags an error.
  task automatic build_expect(int T);
    bit filling = 0;
    int s = 0;
    for (int e = 0; e < T; e++) begin
      if (sched_sip[e]) begin
        if (filling && (e - s) >= 1 && (e - s) <= M - 2) ex_err[e] = 1'b1;
        filling = 1;
        s = e;
      end
      if (filling && (e - s) == M - 1) begin
        for (int j = 0; j < M; j++) begin
          ex_valid[e+1+j] = 1'b1;
          ex_op[e+1+j]    = sched_dat[s + tb_bitrev(j, N)];
          ex_idx[e+1+j]   = 3'(j);
          ex_start[e+1+j] = (j == 0);
        end
        filling = 0;
      end
    end
  endtask

  task automatic check_output(int e);
    check($sformatf("op_valid e%0d", e), op_valid, ex_valid[e]);
    check($sformatf("start_op e%0d", e), start_op, ex_start[e]);
    check($sformatf("frame_err e%0d", e), frame_err, ex_err[e]);
    if (ex_valid[e]) begin
      check($sformatf("op e%0d", e), op, ex_op[e]);
      check($sformatf("op_idx e%0d", e), op_idx, ex_idx[e]);
    end
    if (op_valid)  cnt_valid++;
    if (start_op)  cnt_start++;
    if (frame_err) cnt_err++;
  endtask

  task automatic apply_stimulus(int T);
    cnt_valid = 0;
    cnt_start = 0;
    cnt_err   = 0;
    build_expect(T);
    for (int e = 0; e < T; e++) begin
      @(negedge clk);
      if (e > 0) check_output(e - 1);
      start_ip = sched_sip[e];
      ip       = sched_dat[e];
    end
    @(negedge clk);
    check_output(T - 1);
    start_ip = 1'b0;
    ip       = '0;
  endtask

  initial begin
    int natural_order [8];
    int pos;
    int errs;
    logic [31:0] q [$];

    reset_n   = 1'b1;
    start_ip  = 1'b0;
    ip        = '0;
    start_ip1 = 1'b0;
    ip1       = '0;
    #2 reset_n = 1'b0;
    #1;
    check("reset op", op, 64'h0);
    check("reset op_valid", op_valid, 0);
    check("reset start_op", start_op, 0);
    check("reset op_idx", op_idx, 0);
    check("reset frame_err", frame_err, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Natural-order table for a ramp frame
    natural_order = '{0, 4, 2, 6, 1, 5, 3, 7};
    for (int k = 0; k < 8; k++) begin
      vecs[k].in_re   = 32'(k);
      vecs[k].in_im   = 32'(-k);
      vecs[k].exp_re  = 32'(natural_order[k]);
      vecs[k].exp_im  = 32'(-natural_order[k]);
      vecs[k].exp_idx = 3'(k);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start_ip = (k == 0);
      ip = {vecs[k].in_re, vecs[k].in_im};
    end
    @(negedge clk);
    start_ip = 1'b0;
    ip = '0;
    check("ramp early op_valid", op_valid, 0);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check($sformatf("ramp op_valid %0d", j), op_valid, 1);
      check($sformatf("ramp start_op %0d", j), start_op, (j == 0));
      check($sformatf("ramp op %0d", j), op, {vecs[j].exp_re, vecs[j].exp_im});
      check($sformatf("ramp op_idx %0d", j), op_idx, vecs[j].exp_idx);
    end
    @(negedge clk);
    check("ramp op_valid after frame", op_valid, 0);

    // Reset in the middle of a drain
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start_ip = (k == 0);
      ip = {$urandom(), $urandom()} | 64'h1;
    end
    @(negedge clk);
    start_ip = 1'b0;
    ip = '0;
    repeat (2) @(negedge clk);
    check("middrain op_valid", op_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("middrain reset op", op, 64'h0);
    check("middrain reset op_valid", op_valid, 0);
    check("middrain reset op_idx", op_idx, 0);
    check("middrain reset start_op", start_op, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("post reset idle op_valid %0d", c), op_valid, 0);
      check($sformatf("post reset idle op %0d", c), op, 64'h0);
    end

    // Three back-to-back frames
    do_reset();
    clear_schedule();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < M; k++) begin
        sched_sip[f*M+k] = (k == 0);
        sched_dat[f*M+k] = {32'(100*f + k), 32'(-(100*f + k))};
      end
    end
    apply_stimulus(3*M + 20);
    check("b2b valid count", cnt_valid, 24);
    check("b2b start count", cnt_start, 3);

    // Aborted partial frame followed by a full one
    do_reset();
    clear_schedule();
    for (int k = 0; k < 3; k++) begin
      sched_sip[k] = (k == 0);
      sched_dat[k] = {32'(500 + k), 32'h0};
    end
    for (int k = 0; k < M; k++) begin
      sched_sip[3+k] = (k == 0);
      sched_dat[3+k] = {32'(600 + k), 32'h0};
    end
    apply_stimulus(3 + M + 20);
    check("abort err count", cnt_err, 1);
    check("abort start count", cnt_start, 1);
    check("abort valid count", cnt_valid, 8);

    // New start on the last sample of a frame begins the next frame cleanly
    do_reset();
    errs = 0;
    q.delete();
    for (int e = 0; e < 45; e++) begin
      @(negedge clk);
      if (op_valid) q.push_back(op[63:32]);
      if (frame_err) errs++;
      start_ip = (e == 0) || (e == 7);
      ip = (e < 7) ? {32'(700 + e), 32'h0} : (e < 15) ? {32'(800 + e - 7), 32'h0} : 64'h0;
      if (e >= 15) start_ip = 1'b0;
    end
    check("coincident err count", errs, 0);
    check("coincident valid count", q.size(), 16);
    if (q.size() == 16) begin
      for (int j = 0; j < 8; j++)
        check($sformatf("coincident frame2 op %0d", j), q[8+j], 32'(800 + tb_bitrev(j, N)));
    end

    // N=1 output of a two-point butterfly fed x=[1,1]
    do_reset();
    @(negedge clk);
    start_ip1 = 1'b1;
    ip1 = {32'(1 + 1), 32'h0};
    @(negedge clk);
    start_ip1 = 1'b0;
    ip1 = {32'(1 - 1), 32'h0};
    @(negedge clk);
    ip1 = '0;
    check("n1 early op_valid", op_valid1, 0);
    @(negedge clk);
    check("n1 start_op", start_op1, 1);
    check("n1 op0", op1, {32'd2, 32'd0});
    check("n1 op_idx0", op_idx1, 0);
    @(negedge clk);
    check("n1 op_valid1", op_valid1, 1);
    check("n1 start_op1", start_op1, 0);
    check("n1 op1", op1, {32'd0, 32'd0});
    check("n1 op_idx1", op_idx1, 1);
    @(negedge clk);
    check("n1 op_valid end", op_valid1, 0);
    check("n1 frame_err", frame_err1, 0);

    // Random frames with gaps and occasional aborted fills
    do_reset();
    clear_schedule();
    pos = 0;
    for (int f = 0; f < 50; f++) begin
      if ($urandom_range(0, 4) == 0) begin
        int a = $urandom_range(1, 6);
        for (int k = 0; k < a; k++) begin
          sched_sip[pos+k] = (k == 0);
          sched_dat[pos+k] = {$urandom(), $urandom()};
        end
        pos += a;
      end
      for (int k = 0; k < M; k++) begin
        sched_sip[pos+k] = (k == 0);
        sched_dat[pos+k] = {$urandom(), $urandom()};
      end
      pos += M + $urandom_range(0, 3);
    end
    apply_stimulus(pos + 20);
    check("random frame count", cnt_start, 50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
